// File: rtl/cc_param_data_reorder_unit_if.sv
// R-channel bundle of cc_param_data_reorder_unit: MEM R input, hit flag/data FIFO pushes, INCT R output.
// slave is the reorder unit's view, master is the surrounding environment's view.
interface cc_param_data_reorder_unit_if #(
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 8
);
  localparam int OFS_W      = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int HIT_DATA_W = LINE_BEATS * DATA_W + OFS_W;

  logic [DATA_W-1:0]     mem_rdata_i;
  logic                  mem_rlast_i;
  logic                  mem_rvalid_i;
  logic                  mem_rready_o;
  logic                  hit_flag_fifo_afull_o;
  logic                  hit_flag_fifo_wren_i;
  logic                  hit_flag_fifo_wdata_i;
  logic                  hit_data_fifo_afull_o;
  logic                  hit_data_fifo_wren_i;
  logic [HIT_DATA_W-1:0] hit_data_fifo_wdata_i;
  logic [DATA_W-1:0]     inct_rdata_o;
  logic                  inct_rlast_o;
  logic                  inct_rvalid_o;
  logic                  inct_rready_i;

  modport slave (
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    input  hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    input  hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    input  inct_rready_i,
    output mem_rready_o, hit_flag_fifo_afull_o, hit_data_fifo_afull_o,
    output inct_rdata_o, inct_rlast_o, inct_rvalid_o
  );

  modport master (
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    output hit_flag_fifo_wren_i, hit_flag_fifo_wdata_i,
    output hit_data_fifo_wren_i, hit_data_fifo_wdata_i,
    output inct_rready_i,
    input  mem_rready_o, hit_flag_fifo_afull_o, hit_data_fifo_afull_o,
    input  inct_rdata_o, inct_rlast_o, inct_rvalid_o
  );
endinterface

// File: rtl/cc_param_data_reorder_unit.sv
// Cache-controller R reorder: merges hit lines (critical word first) and MEM miss bursts in flag order.
// Optional macro CC_DRU_PERF_CNT_EN adds saturating hit_cnt_o / miss_cnt_o burst counters.
module cc_param_data_reorder_unit_fifo #(
  parameter int W            = 1,
  parameter int DEPTH        = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      afull  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
      afull <= (count >= AFULL_TH);
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full)) else $warning("push into full reorder FIFO dropped");
  end
endmodule

module cc_param_data_reorder_unit #(
  parameter int DATA_W       = 64,
  parameter int LINE_BEATS   = 8,
  parameter int FLAG_DEPTH   = 16,
  parameter int DATA_DEPTH   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input logic clk,
  input logic rst,
  cc_param_data_reorder_unit_if.slave bus
`ifdef CC_DRU_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int OFS_W      = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int BIDX_W     = $clog2(LINE_BEATS);
  localparam int LINE_W     = LINE_BEATS * DATA_W;
  localparam int HIT_DATA_W = LINE_W + OFS_W;
  localparam logic [BIDX_W-1:0] LAST_K = BIDX_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HIT, MISS} state_t;

  state_t                state_q;
  logic [LINE_W-1:0]     line_q;
  logic [BIDX_W-1:0]     idx_q, k_q, idx_nxt, k_nxt;
  logic [DATA_W-1:0]     hit_rdata_q;
  logic                  hit_rlast_q;

  logic                  flag_head, flag_empty, flag_pop;
  logic [HIT_DATA_W-1:0] data_head;
  logic                  data_empty, data_pop;
  logic [LINE_W-1:0]     data_line;
  logic [BIDX_W-1:0]     data_start;
  logic                  hit_last_hs, miss_last_hs;

  cc_param_data_reorder_unit_fifo #(
    .W(1), .DEPTH(FLAG_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
  ) u_flag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.hit_flag_fifo_wren_i),
    .wdata (bus.hit_flag_fifo_wdata_i),
    .pop   (flag_pop),
    .rdata (flag_head),
    .empty (flag_empty),
    .afull (bus.hit_flag_fifo_afull_o)
  );

  cc_param_data_reorder_unit_fifo #(
    .W(HIT_DATA_W), .DEPTH(DATA_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.hit_data_fifo_wren_i),
    .wdata (bus.hit_data_fifo_wdata_i),
    .pop   (data_pop),
    .rdata (data_head),
    .empty (data_empty),
    .afull (bus.hit_data_fifo_afull_o)
  );

  // Only the beat-index bits of the byte offset matter; the sub-beat bits are ignored.
  assign data_line  = data_head[LINE_W-1:0];
  assign data_start = data_head[HIT_DATA_W-1 -: BIDX_W];
  if (OFS_W > BIDX_W) begin : g_ofs_lsb
    logic unused_ofs_lsb;
    assign unused_ofs_lsb = ^data_head[LINE_W +: OFS_W - BIDX_W];
  end

  assign idx_nxt      = idx_q + BIDX_W'(1);
  assign k_nxt        = k_q + BIDX_W'(1);
  assign hit_last_hs  = (state_q == HIT) && bus.inct_rready_i && (k_q == LAST_K);
  assign miss_last_hs = (state_q == MISS) && bus.mem_rvalid_i && bus.inct_rready_i
                        && bus.mem_rlast_i;

  function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [BIDX_W-1:0] idx);
    return line[int'(idx) * DATA_W +: DATA_W];
  endfunction

  // A hit flag waits at the head until its line is in the data FIFO.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    flag_pop = 1'b0;
    data_pop = 1'b0;
    if (state_q == IDLE && !flag_empty) begin
      if (!flag_head) begin
        flag_pop = 1'b1;
      end else if (!data_empty) begin
        flag_pop = 1'b1;
        data_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      hit_rdata_q <= '0;
      hit_rlast_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_pop) begin
            line_q      <= data_line;
            idx_q       <= data_start;
            k_q         <= '0;
            hit_rdata_q <= word_sel(data_line, data_start);
            hit_rlast_q <= 1'b0;
            state_q     <= HIT;
          end else if (flag_pop) begin
            state_q <= MISS;
          end
        end
        HIT: begin
          if (hit_last_hs) begin
            hit_rlast_q <= 1'b0;
            state_q     <= IDLE;
          end else if (bus.inct_rready_i) begin
            k_q         <= k_nxt;
            idx_q       <= idx_nxt;
            hit_rdata_q <= word_sel(line_q, idx_nxt);
            hit_rlast_q <= (k_nxt == LAST_K);
          end
        end
        MISS: begin
          if (miss_last_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Miss bursts bypass all registers; MEM is only ever connected while in MISS.
  always_comb begin
    bus.inct_rvalid_o = 1'b0;
    bus.inct_rdata_o  = '0;
    bus.inct_rlast_o  = 1'b0;
    bus.mem_rready_o  = 1'b0;
    unique case (state_q)
      HIT: begin
        bus.inct_rvalid_o = 1'b1;
        bus.inct_rdata_o  = hit_rdata_q;
        bus.inct_rlast_o  = hit_rlast_q;
      end
      MISS: begin
        bus.inct_rvalid_o = bus.mem_rvalid_i;
        bus.inct_rdata_o  = bus.mem_rdata_i;
        bus.inct_rlast_o  = bus.mem_rlast_i;
        bus.mem_rready_o  = bus.inct_rready_i;
      end
      default: ;
    endcase
  end

`ifdef CC_DRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_last_hs && hit_cnt_o != '1)   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_last_hs && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cc_param_data_reorder_unit.sv
// Directed bench for cc_param_data_reorder_unit: scoreboard of expected INCT beats, immediate-assert checks.
module tb_cc_param_data_reorder_unit;
  localparam int DW  = 64;
  localparam int LB  = 8;
  localparam int LW  = DW * LB;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          hit;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic  stab_en = 1'b0;
  logic  held_v  = 1'b0;
  logic [DW-1:0] held_d;
  logic [LW-1:0] line;

  cc_param_data_reorder_unit_if #(.DATA_W(DW), .LINE_BEATS(LB)) bus ();

`ifdef CC_DRU_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  cc_param_data_reorder_unit #(
    .DATA_W(DW), .LINE_BEATS(LB), .FLAG_DEPTH(16), .DATA_DEPTH(4), .AFULL_MARGIN(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CC_DRU_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [DW-1:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < LB; i++) l[i*DW +: DW] = base + DW'(i);
    return l;
  endfunction

  // Expected critical-word-first replay of one hit line.
  task automatic exp_hit(input logic [5:0] ofs, input logic [LW-1:0] l);
    int start;
    start = int'(ofs[5:3]);
    for (int k = 0; k < LB; k++)
      exp_q.push_back('{l[((start + k) % LB)*DW +: DW], (k == LB-1), 1'b1});
  endtask

  task automatic push(input logic fl_en, input logic fl_val, input logic d_en,
                      input logic [5:0] ofs, input logic [LW-1:0] l);
    bus.hit_flag_fifo_wren_i  = fl_en;
    bus.hit_flag_fifo_wdata_i = fl_val;
    bus.hit_data_fifo_wren_i  = d_en;
    bus.hit_data_fifo_wdata_i = {ofs, l};
    tick();
    bus.hit_flag_fifo_wren_i  = 1'b0;
    bus.hit_data_fifo_wren_i  = 1'b0;
  endtask

  task automatic mem_beat(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    exp_q.push_back('{d, l, 1'b0});
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = d;
    bus.mem_rlast_i  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_rready_o && n < 50);
    check("mem_rready_seen", 64'(bus.mem_rready_o), 64'd1);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rvalid"}, 64'(bus.inct_rvalid_o), 64'd0);
    check({tag, "_rlast"}, 64'(bus.inct_rlast_o), 64'd0);
    check({tag, "_rdata"}, bus.inct_rdata_o, 64'd0);
    check({tag, "_mem_rready"}, 64'(bus.mem_rready_o), 64'd0);
    check({tag, "_flag_afull"}, 64'(bus.hit_flag_fifo_afull_o), 64'd0);
    check({tag, "_data_afull"}, 64'(bus.hit_data_fifo_afull_o), 64'd0);
  endtask

  // Scoreboard: a beat seen valid&ready at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (bus.inct_rvalid_o && bus.inct_rready_i) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rdata", bus.inct_rdata_o, mon_e.data);
        check("rlast", 64'(bus.inct_rlast_o), 64'(mon_e.last));
        if (mon_e.hit) check("mem_rready_in_hit", 64'(bus.mem_rready_o), 64'd0);
      end
    end
    if (stab_en && held_v) begin
      check("stall_rvalid", 64'(bus.inct_rvalid_o), 64'd1);
      check("stall_rdata", bus.inct_rdata_o, held_d);
    end
    held_v = stab_en && bus.inct_rvalid_o && !bus.inct_rready_i;
    held_d = bus.inct_rdata_o;
  end

  initial begin
    rst                       = 1'b1;
    bus.mem_rdata_i           = '0;
    bus.mem_rlast_i           = 1'b0;
    bus.mem_rvalid_i          = 1'b0;
    bus.hit_flag_fifo_wren_i  = 1'b0;
    bus.hit_flag_fifo_wdata_i = 1'b0;
    bus.hit_data_fifo_wren_i  = 1'b0;
    bus.hit_data_fifo_wdata_i = '0;
    bus.inct_rready_i         = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_idle("reset");
    tick();
    rst = 1'b0;
    tick();

    // Hit with start beat 3, no stalls.
    bus.inct_rready_i = 1'b1;
    exp_hit(6'h18, mk_line(64'h0));
    push(1'b1, 1'b1, 1'b1, 6'h18, mk_line(64'h0));
    wait_drain(30);

    // Miss then hit; MEM keeps offering a junk beat during the hit burst.
    push(1'b1, 1'b0, 1'b0, 6'h00, '0);
    push(1'b1, 1'b1, 1'b1, 6'h38, mk_line(64'hB0));
    for (int i = 0; i < LB; i++) mem_beat(64'hA0 + 64'(i), (i == LB-1));
    exp_hit(6'h38, mk_line(64'hB0));
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEAD_BEEF;
    bus.mem_rlast_i  = 1'b1;
    wait_drain(30);
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;

    // Hit flag waiting on its data line.
    push(1'b1, 1'b1, 1'b0, 6'h00, '0);
    repeat (5) begin
      @(negedge clk);
      check("nodata_rvalid", 64'(bus.inct_rvalid_o), 64'd0);
    end
    tick();
    exp_hit(6'h10, mk_line(64'hC0));
    push(1'b0, 1'b0, 1'b1, 6'h10, mk_line(64'hC0));
    @(negedge clk);
    check("lat_bubble_rvalid", 64'(bus.inct_rvalid_o), 64'd0);
    tick();
    @(negedge clk);
    check("lat_first_rvalid", 64'(bus.inct_rvalid_o), 64'd1);
    wait_drain(30);

    // Random 50% back-pressure on a hit line.
    for (int i = 0; i < LB; i++) line[i*DW +: DW] = {$urandom, $urandom};
    stab_en = 1'b1;
    exp_hit(6'h00, line);
    push(1'b1, 1'b1, 1'b1, 6'h00, line);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      bus.inct_rready_i = 1'($urandom_range(0, 1));
      tick();
    end
    bus.inct_rready_i = 1'b1;
    wait_drain(30);
    stab_en = 1'b0;

    // Flag FIFO almost-full, pop, fill to full, and a dropped push at full.
    bus.inct_rready_i = 1'b0;
    push(1'b1, 1'b1, 1'b0, 6'h00, '0);
    repeat (13) push(1'b1, 1'b0, 1'b0, 6'h00, '0);
    tick();
    tick();
    @(negedge clk);
    check("afull_at_14", 64'(bus.hit_flag_fifo_afull_o), 64'd1);
    tick();
    exp_hit(6'h00, mk_line(64'hE0));
    push(1'b0, 1'b0, 1'b1, 6'h00, mk_line(64'hE0));
    tick();
    tick();
    @(negedge clk);
    check("afull_after_pop", 64'(bus.hit_flag_fifo_afull_o), 64'd0);
    tick();
    repeat (4) push(1'b1, 1'b0, 1'b0, 6'h00, '0);
    tick();
    tick();
    @(negedge clk);
    check("afull_at_full", 64'(bus.hit_flag_fifo_afull_o), 64'd1);
    tick();
    bus.inct_rready_i = 1'b1;
    wait_drain(30);
    for (int i = 0; i < 16; i++) mem_beat(64'h5000 + 64'(i), 1'b1);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h5555;
    bus.mem_rlast_i  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("full_drop_rvalid", 64'(bus.inct_rvalid_o), 64'd0);
      check("full_drop_mem_rready", 64'(bus.mem_rready_o), 64'd0);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;

`ifdef CC_DRU_PERF_CNT_EN
    check("hit_cnt_pre_rst", 64'(hit_cnt), 64'd5);
    check("miss_cnt_pre_rst", 64'(miss_cnt), 64'd17);
`endif

    // Reset in the middle of a hit burst with both FIFOs loaded.
    bus.inct_rready_i = 1'b0;
    exp_hit(6'h18, mk_line(64'h700));
    push(1'b1, 1'b1, 1'b1, 6'h18, mk_line(64'h700));
    repeat (2) push(1'b1, 1'b0, 1'b1, 6'h00, mk_line(64'h900));
    repeat (12) push(1'b1, 1'b0, 1'b0, 6'h00, '0);
    tick();
    tick();
    @(negedge clk);
    check("rst_pre_flag_afull", 64'(bus.hit_flag_fifo_afull_o), 64'd1);
    check("rst_pre_data_afull", 64'(bus.hit_data_fifo_afull_o), 64'd1);
    tick();
    bus.inct_rready_i = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() > 4; n++) tick();
    check("rst_reach_beat4", 64'(exp_q.size()), 64'd4);
    rst               = 1'b1;
    bus.inct_rready_i = 1'b0;
    exp_q.delete();
    tick();
    @(negedge clk);
    check_idle("mid_rst");
`ifdef CC_DRU_PERF_CNT_EN
    check("hit_cnt_rst", 64'(hit_cnt), 64'd0);
    check("miss_cnt_rst", 64'(miss_cnt), 64'd0);
`endif
    tick();
    rst               = 1'b0;
    bus.inct_rready_i = 1'b1;
    bus.mem_rvalid_i  = 1'b1;
    bus.mem_rdata_i   = 64'h6666;
    bus.mem_rlast_i   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_rvalid", 64'(bus.inct_rvalid_o), 64'd0);
    end
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
    exp_hit(6'h08, mk_line(64'h800));
    push(1'b1, 1'b1, 1'b1, 6'h08, mk_line(64'h800));
    wait_drain(30);
`ifdef CC_DRU_PERF_CNT_EN
    check("hit_cnt_end", 64'(hit_cnt), 64'd1);
    check("miss_cnt_end", 64'(miss_cnt), 64'd0);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
